// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo block.
package sync_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    // Number of entries addressed by an aw-bit pointer.
    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: synchronous write port, synchronous registered read port.
// Storage is not reset; only the read register clears on rst.
module dual_port_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read register holds its value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock valid/ready FIFO with registered occupancy count.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_data,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   fifo_size
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_ready   = (r_count != (ADDR_WIDTH+1)'(DEPTH));
    assign r_ready   = (r_count != '0);
    assign w_wr_acc  = w_en && w_ready;
    assign w_rd_acc  = r_en && r_ready;
    assign fifo_size = r_count;

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_en && !w_ready) begin
                r_overflow <= 1'b1;
            end
            if (r_en && !r_ready) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr),
        .wdata (w_data),
        .re    (w_rd_acc),
        .raddr (r_rd_ptr),
        .rdata (r_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (depth 16, 32-bit words).
module tb_sync_fifo;

    logic        clk;
    logic        rst;
    logic        w_en;
    logic        w_ready;
    logic [31:0] w_data;
    logic        r_en;
    logic        r_ready;
    logic [31:0] r_data;
    logic [4:0]  fifo_size;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    int total = 0;
    int bad   = 0;

    sync_fifo #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_en      (w_en),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .r_en      (r_en),
        .r_ready   (r_ready),
        .r_data    (r_data),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .fifo_size (fifo_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; w_data = '0;
        tick();
        tick();
        rst = 1'b0;
        total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL reset_w_ready got=%b exp=1", w_ready); end
        total++; if (r_ready !== 1'b0) begin bad++; $display("FAIL reset_r_ready got=%b exp=0", r_ready); end
        total++; if (fifo_size !== 5'd0) begin bad++; $display("FAIL reset_size got=%0d exp=0", fifo_size); end
        total++; if (r_data !== 32'd0) begin bad++; $display("FAIL reset_r_data got=%0h exp=0", r_data); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
`endif
    endtask

    task automatic test_fill();
        w_en = 1'b1; r_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            w_data = 32'(i);
            total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, w_ready); end
            tick();
            total++; if (fifo_size !== 5'(i)) begin bad++; $display("FAIL fill_size[%0d] got=%0d exp=%0d", i, fifo_size, i); end
        end
        total++; if (w_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", w_ready); end
        w_data = 32'd99;
        tick();
        w_en = 1'b0;
        total++; if (fifo_size !== 5'd16) begin bad++; $display("FAIL fill_overflow_size got=%0d exp=16", fifo_size); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow_flag got=%b exp=1", overflow); end
`endif
    endtask

    task automatic test_drain();
        w_en = 1'b0; r_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            total++; if (r_data !== 32'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", i, r_data, i); end
            total++; if (fifo_size !== 5'(16 - i)) begin bad++; $display("FAIL drain_size[%0d] got=%0d exp=%0d", i, fifo_size, 16 - i); end
        end
        total++; if (r_ready !== 1'b0) begin bad++; $display("FAIL drain_empty_ready got=%b exp=0", r_ready); end
        tick();
        r_en = 1'b0;
        total++; if (r_data !== 32'd16) begin bad++; $display("FAIL drain_hold_data got=%0d exp=16", r_data); end
        total++; if (fifo_size !== 5'd0) begin bad++; $display("FAIL drain_hold_size got=%0d exp=0", fifo_size); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL drain_underflow_flag got=%b exp=1", underflow); end
`endif
    endtask

    task automatic test_stream();
        logic [31:0] nxt_w;
        logic [31:0] exp_r;
        logic        acc_w;
        logic        acc_r;
        nxt_w = 32'd1000; exp_r = 32'd1000;
        w_en = 1'b1; r_en = 1'b0;
        for (int c = 0; c < 30; c++) begin
            acc_w = w_ready;
            w_data = nxt_w;
            tick();
            if (acc_w) nxt_w++;
        end
        total++; if (fifo_size !== 5'd16) begin bad++; $display("FAIL stream_prefill_size got=%0d exp=16", fifo_size); end
        total++; if (nxt_w !== 32'd1016) begin bad++; $display("FAIL stream_prefill_count got=%0d exp=1016", nxt_w); end
        r_en = 1'b1;
        for (int c = 0; c < 41; c++) begin
            acc_w = w_ready;
            acc_r = r_ready;
            w_data = nxt_w;
            tick();
            if (acc_w) nxt_w++;
            if (acc_r) begin
                total++; if (r_data !== exp_r) begin bad++; $display("FAIL stream_data[%0d] got=%0d exp=%0d", c, r_data, exp_r); end
                exp_r++;
            end
            total++; if (fifo_size !== 5'd15) begin bad++; $display("FAIL stream_size[%0d] got=%0d exp=15", c, fifo_size); end
        end
        w_en = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            total++; if (r_data !== exp_r) begin bad++; $display("FAIL stream_tail[%0d] got=%0d exp=%0d", c, r_data, exp_r); end
            exp_r++;
        end
        r_en = 1'b0;
        total++; if (exp_r !== 32'd1056 || fifo_size !== 5'd0) begin bad++; $display("FAIL stream_end got=%0d/%0d exp=1056/0", exp_r, fifo_size); end
    endtask

    task automatic test_simul_full();
        w_en = 1'b1; r_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            w_data = 32'(i);
            tick();
        end
        total++; if (fifo_size !== 5'd16) begin bad++; $display("FAIL simfull_pre got=%0d exp=16", fifo_size); end
        r_en = 1'b1; w_data = 32'd77;
        tick();
        total++; if (fifo_size !== 5'd15) begin bad++; $display("FAIL simfull_size got=%0d exp=15", fifo_size); end
        total++; if (r_data !== 32'd1) begin bad++; $display("FAIL simfull_data got=%0d exp=1", r_data); end
        w_en = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick();
            total++; if (r_data !== 32'(i)) begin bad++; $display("FAIL simfull_drain[%0d] got=%0d exp=%0d", i, r_data, i); end
        end
        r_en = 1'b0;
        total++; if (fifo_size !== 5'd0) begin bad++; $display("FAIL simfull_end got=%0d exp=0", fifo_size); end
    endtask

    task automatic test_simul_empty();
        w_en = 1'b1; r_en = 1'b1; w_data = 32'd55;
        tick();
        total++; if (fifo_size !== 5'd1) begin bad++; $display("FAIL simempty_size got=%0d exp=1", fifo_size); end
        total++; if (r_data !== 32'd16) begin bad++; $display("FAIL simempty_data got=%0d exp=16", r_data); end
        w_en = 1'b0;
        tick();
        r_en = 1'b0;
        total++; if (r_data !== 32'd55) begin bad++; $display("FAIL simempty_read got=%0d exp=55", r_data); end
        total++; if (fifo_size !== 5'd0) begin bad++; $display("FAIL simempty_end got=%0d exp=0", fifo_size); end
    endtask

    task automatic test_single();
        w_en = 1'b1; r_en = 1'b0; w_data = 32'hDEADBEEF;
        tick();
        w_en = 1'b0;
        total++; if (r_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", r_ready); end
        total++; if (r_data !== 32'd55) begin bad++; $display("FAIL single_nodata got=%0h exp=37", r_data); end
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        total++; if (r_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%0h exp=deadbeef", r_data); end
        total++; if (fifo_size !== 5'd0) begin bad++; $display("FAIL single_size got=%0d exp=0", fifo_size); end
    endtask

    task automatic test_reset_mid();
        w_en = 1'b1; r_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_data = 32'(200 + i);
            tick();
        end
        w_en = 1'b0;
        total++; if (fifo_size !== 5'd5) begin bad++; $display("FAIL rstmid_pre got=%0d exp=5", fifo_size); end
        #1 rst = 1'b1;
        #1;
        total++; if (fifo_size !== 5'd0) begin bad++; $display("FAIL rstmid_size got=%0d exp=0", fifo_size); end
        total++; if (r_ready !== 1'b0) begin bad++; $display("FAIL rstmid_r_ready got=%b exp=0", r_ready); end
        total++; if (w_ready !== 1'b1 || r_data !== 32'd0) begin bad++; $display("FAIL rstmid_misc got=%b/%0h exp=1/0", w_ready, r_data); end
        tick();
        rst = 1'b0;
        w_en = 1'b1; w_data = 32'd9;
        tick();
        w_en = 1'b0; r_en = 1'b1;
        total++; if (fifo_size !== 5'd1) begin bad++; $display("FAIL rstmid_post_size got=%0d exp=1", fifo_size); end
        tick();
        r_en = 1'b0;
        total++; if (r_data !== 32'd9) begin bad++; $display("FAIL rstmid_post_data got=%0d exp=9", r_data); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_simul_full();
        test_simul_empty();
        test_single();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
